multi_debounce: RTL and testbench
=================================

// Module: multi_debounce
// PURPOSE
//  Parametrised multi-channel debouncer: N asynchronous inputs (buttons, switches, strap lines).
//  Each channel has a synchroniser and a tick-qualified stability counter. Outputs are a clean
//  level plus one-cycle rise/fall pulses. Shares the system ms_tck strobe with the
//  single-channel debounce; replaces per-signal instances in the top level.
// PARAMETERS
//  CHANNELS     4     number of independent input channels (>=1)
//  TIME         5     consecutive ms_tck strobes an input must differ from sig_out before it is accepted (>=1)
//  CNT_W        7     stability counter width; TIME <= 2**CNT_W-1 required
//  SYNC_STAGES  2     synchroniser flops per channel (>=2)
//  INIT_LEVEL   1'b1  reset value of synchroniser and sig_out (inputs idle high)
//  HOLD_TIME    1000  ms_tck strobes for long_press (LONG_PRESS_EN only)
//  HOLD_W       10    hold counter width; HOLD_TIME <= 2**HOLD_W-1 required
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         synchronous reset, active low
//  ms_tck     in   1         one-clk strobe, nominally 1 ms period
//  sig_in     in   CHANNELS  raw asynchronous inputs
//  sig_out    out  CHANNELS  debounced levels
//  rise       out  CHANNELS  one-clk pulse when sig_out[i] goes 0->1
//  fall       out  CHANNELS  one-clk pulse when sig_out[i] goes 1->0
//  any_change out  1         registered OR of rise|fall, same cycle as the pulses
//  long_press out  CHANNELS  one-clk pulse per active hold (0 when LONG_PRESS_EN undefined)
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge clk): sync chain and sig_out = {CHANNELS{INIT_LEVEL}}; counters = 0;
//    rise/fall/any_change/long_press = 0. Reset mid-count discards progress; no pulse on reset exit.
//  - Per channel, s = last sync stage. Every clk with s==sig_out[i]: cnt[i] <= 0 (any glitch restarts).
//  - s!=sig_out[i] and ms_tck==1: if cnt[i]==TIME-1, sig_out[i] <= s, cnt[i] <= 0, rise/fall pulses
//    on the same edge; else cnt[i] <= cnt[i]+1. s!=sig_out[i] and ms_tck==0: cnt[i] holds.
//  - Simultaneous: s returns to sig_out[i] on a ms_tck cycle -> clear wins, no increment.
//  - Latency: SYNC_STAGES clks + TIME ms_tck strobes after the last input edge; sig_out changes
//    on the edge that samples the TIME-th strobe. Worst case TIME*period + SYNC_STAGES clks.
//  - Counter never exceeds TIME-1; no wrap. Channels fully independent; any subset may change in
//    one cycle. rise/fall are mutually exclusive per channel and last exactly one clk.
//  - ms_tck held high for multiple clks counts once per clk (caller guarantees one-clk strobe).
// CONFIGURATION
//  LONG_PRESS_EN defined: per-channel hold counter counts ms_tck while sig_out[i]==~INIT_LEVEL;
//    on the HOLD_TIME-th strobe long_press[i] pulses one clk, then the counter freezes (one pulse
//    per press). Counter clears when sig_out[i] returns to INIT_LEVEL or on reset.
//  LONG_PRESS_EN undefined: no hold counters synthesised; long_press tied to 0; port list unchanged.
// TESTING (CHANNELS=4, TIME=5, INIT_LEVEL=1, ms_tck every 3 clks, 20 ns clk)
//  1 Reset: rst_n=0 two clks -> sig_out=4'hF, rise=fall=any_change=long_press=0.
//  2 Bounce ch0: 9 toggles at 5 ns spacing ending low -> sig_out[0] stays 1 while bouncing,
//    falls after 5 further strobes; fall[0] one clk, any_change one clk, ch1-3 unchanged.
//  3 Short glitch: ch2 low for 3 strobes then high -> no sig_out/rise/fall change, cnt restarts.
//  4 Simultaneous: ch1 and ch3 go low same clk -> both fall pulses on the same edge, any_change=1 once.
//  5 Release: ch0 back high, stable 5 strobes -> rise[0] one clk, sig_out[0]=1.
//  6 LONG_PRESS_EN, HOLD_TIME=10: ch0 held low -> long_press[0] one clk on 10th strobe after fall,
//    none after; without macro long_press stays 0. Reset asserted mid-count -> all outputs to reset values.

Source files
------------

// File: rtl/multi_debounce.sv
// Multi-channel debouncer: per-channel synchroniser, ms_tck-qualified stability counter, rise/fall pulses.
// Optional per-channel long-press detector is built when LONG_PRESS_EN is defined.
module multi_debounce #(
   parameter int   CHANNELS    = 4,
   parameter int   TIME        = 5,
   parameter int   CNT_W       = 7,
   parameter int   SYNC_STAGES = 2,
   parameter logic INIT_LEVEL  = 1'b1,
   parameter int   HOLD_TIME   = 1000,
   parameter int   HOLD_W      = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ms_tck,
   input  logic [CHANNELS-1:0] sig_in,
   output logic [CHANNELS-1:0] sig_out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_change,
   output logic [CHANNELS-1:0] long_press
);

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIME - 1);

   logic [CHANNELS-1:0] w_rise_next;
   logic [CHANNELS-1:0] w_fall_next;
   logic                r_any;

   if (CHANNELS < 1 || TIME < 1 || TIME > (2**CNT_W) - 1 || SYNC_STAGES < 2 ||
       HOLD_TIME < 1 || HOLD_TIME > (2**HOLD_W) - 1) begin : g_param_check
      $error("multi_debounce: parameter out of range");
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] r_sync;
         logic [CNT_W-1:0]       r_cnt;
         logic                   r_out;
         logic                   r_rise;
         logic                   r_fall;
         logic                   w_s;
         logic                   w_diff;
         logic                   w_accept;

         assign w_s      = r_sync[SYNC_STAGES-1];
         assign w_diff   = w_s ^ r_out;
         assign w_accept = w_diff & ms_tck & (r_cnt == LP_CNT_LAST);

         assign w_rise_next[gi] = w_accept & w_s;
         assign w_fall_next[gi] = w_accept & ~w_s;

         // Any cycle where the synchronised input agrees with the output restarts the count.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_sync <= {SYNC_STAGES{INIT_LEVEL}};
               r_cnt  <= '0;
               r_out  <= INIT_LEVEL;
               r_rise <= 1'b0;
               r_fall <= 1'b0;
            end else begin
               r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in[gi]};
               r_rise <= w_rise_next[gi];
               r_fall <= w_fall_next[gi];
               if (!w_diff) begin
                  r_cnt <= '0;
               end else if (ms_tck) begin
                  if (w_accept) begin
                     r_out <= w_s;
                     r_cnt <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
         end

         assign sig_out[gi] = r_out;
         assign rise[gi]    = r_rise;
         assign fall[gi]    = r_fall;

`ifdef LONG_PRESS_EN
         localparam logic [HOLD_W-1:0] LP_HOLD_LAST = HOLD_W'(HOLD_TIME - 1);
         logic [HOLD_W-1:0] r_hold;
         logic              r_long;

         // Counter saturates at HOLD_TIME so each press yields a single pulse.
         always_ff @(posedge clk) begin
            if (!rst_n || (r_out == INIT_LEVEL)) begin
               r_hold <= '0;
               r_long <= 1'b0;
            end else begin
               r_long <= 1'b0;
               if (ms_tck && (r_hold <= LP_HOLD_LAST)) begin
                  r_hold <= r_hold + 1'b1;
                  r_long <= (r_hold == LP_HOLD_LAST);
               end
            end
         end

         assign long_press[gi] = r_long;
`else
         assign long_press[gi] = 1'b0;
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_any <= 1'b0;
      end else begin
         r_any <= |(w_rise_next | w_fall_next);
      end
   end

   assign any_change = r_any;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce: vector table of input phases plus hand-written bounce,
// exact-latency, reset-mid-count and long-press sequences. Define LONG_PRESS_EN to test long_press.
module tb_multi_debounce;

   localparam int N = 4;

`ifdef LONG_PRESS_EN
   localparam logic [3:0] EXP_LP = 4'b0101;
`else
   localparam logic [3:0] EXP_LP = 4'b0000;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ms_tck = 1'b0;
   logic [N-1:0] sig_in = 4'hF;
   logic [N-1:0] sig_out, rise, fall, long_press;
   logic         any_change;

   multi_debounce #(.CHANNELS(N), .TIME(5), .CNT_W(7), .SYNC_STAGES(2), .INIT_LEVEL(1'b1),
                    .HOLD_TIME(10), .HOLD_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .ms_tck(ms_tck), .sig_in(sig_in), .sig_out(sig_out),
      .rise(rise), .fall(fall), .any_change(any_change), .long_press(long_press));

   always #10 clk = ~clk;

   typedef struct {
      logic [3:0] in;
      int         strobes;
      logic [3:0] exp_out;
      logic [3:0] exp_rise;
      logic [3:0] exp_fall;
      int         exp_any;
   } vec_t;

   vec_t vecs [7];

   int checks = 0;
   int errors = 0;
   int strobes = 0;
   int tick_phase = 0;
   int rise_cnt [N];
   int fall_cnt [N];
   int lp_cnt [N];
   int any_cnt = 0;
   int lp_total = 0;
   logic [N-1:0] prev_out = 4'hF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < N; i++) begin
         rise_cnt[i] = 0;
         fall_cnt[i] = 0;
         lp_cnt[i]   = 0;
      end
      any_cnt = 0;
   endtask

   // One clock: sample outputs at negedge, then drive ms_tck for the next posedge.
   task automatic cycle();
      @(negedge clk);
      if (ms_tck) strobes++;
      chk("rise_vs_level", {28'd0, rise}, {28'd0, ~prev_out & sig_out});
      chk("fall_vs_level", {28'd0, fall}, {28'd0, prev_out & ~sig_out});
      chk("any_vs_pulses", {31'd0, any_change}, {31'd0, |(rise | fall)});
      for (int i = 0; i < N; i++) begin
         rise_cnt[i] += int'(rise[i]);
         fall_cnt[i] += int'(fall[i]);
         lp_cnt[i]   += int'(long_press[i]);
         lp_total    += int'(long_press[i]);
      end
      any_cnt += int'(any_change);
      prev_out = sig_out;
      tick_phase = (tick_phase + 1) % 3;
      ms_tck = (tick_phase == 2);
   endtask

   task automatic wait_strobes(input int n);
      int target;
      target = strobes + n;
      while (strobes < target) cycle();
   endtask

   task automatic chk_counts(input string name, input logic [3:0] er, input logic [3:0] ef, input int ea);
      for (int i = 0; i < N; i++) begin
         chk({name, "_rise"}, rise_cnt[i], {31'd0, er[i]});
         chk({name, "_fall"}, fall_cnt[i], {31'd0, ef[i]});
      end
      chk({name, "_any"}, any_cnt, ea);
   endtask

   task automatic apply_vec(input int idx);
      clear_counts();
      sig_in = vecs[idx].in;
      wait_strobes(vecs[idx].strobes);
      chk($sformatf("vec%0d_out", idx), {28'd0, sig_out}, {28'd0, vecs[idx].exp_out});
      chk_counts($sformatf("vec%0d", idx), vecs[idx].exp_rise, vecs[idx].exp_fall, vecs[idx].exp_any);
      $display("vec %0d: in=%b out=%b rise_cnt0=%0d fall_cnt0=%0d any=%0d", idx, vecs[idx].in,
               sig_out, rise_cnt[0], fall_cnt[0], any_cnt);
   endtask

   initial begin
      int base;
      int guard;

      vecs[0] = '{4'hF,    4, 4'hF,    4'b0000, 4'b0000, 0};
      vecs[1] = '{4'b1010, 3, 4'b1110, 4'b0000, 4'b0000, 0};
      vecs[2] = '{4'b1110, 2, 4'b1110, 4'b0000, 4'b0000, 0};
      vecs[3] = '{4'b1010, 4, 4'b1110, 4'b0000, 4'b0000, 0};
      vecs[4] = '{4'b1110, 2, 4'b1110, 4'b0000, 4'b0000, 0};
      vecs[5] = '{4'b0100, 7, 4'b0100, 4'b0000, 4'b1010, 1};
      vecs[6] = '{4'hF,    7, 4'hF,    4'b1010, 4'b0000, 1};

      clear_counts();

      // Reset
      rst_n = 1'b0;
      cycle();
      cycle();
      chk("reset_out", {28'd0, sig_out}, 32'hF);
      chk("reset_rise", {28'd0, rise}, 32'h0);
      chk("reset_fall", {28'd0, fall}, 32'h0);
      chk("reset_any", {31'd0, any_change}, 32'h0);
      chk("reset_lp", {28'd0, long_press}, 32'h0);
      $display("reset: out=%b rise=%b fall=%b any=%b lp=%b", sig_out, rise, fall, any_change, long_press);
      rst_n = 1'b1;

      apply_vec(0);

      // Bounce on ch0, ending low
      clear_counts();
      fork
         begin
            #3;
            for (int k = 0; k < 9; k++) begin
               sig_in[0] = ~sig_in[0];
               #5;
            end
         end
         begin
            repeat (3) cycle();
         end
      join
      chk("bounce_hold", {31'd0, sig_out[0]}, 32'h1);
      wait_strobes(3);
      chk("bounce_early", {31'd0, sig_out[0]}, 32'h1);
      wait_strobes(5);
      chk("bounce_out", {28'd0, sig_out}, 32'hE);
      chk_counts("bounce", 4'b0000, 4'b0001, 1);
      $display("bounce: out=%b fall_cnt0=%0d any=%0d", sig_out, fall_cnt[0], any_cnt);

      for (int v = 1; v <= 5; v++) apply_vec(v);

      // Release ch0 with exact latency: 2 sync clocks then 5 counted strobes
      clear_counts();
      sig_in = 4'b0101;
      cycle();
      cycle();
      base = strobes;
      while (strobes < base + 4) cycle();
      chk("release_early", {31'd0, sig_out[0]}, 32'h0);
      while (strobes < base + 5) cycle();
      chk("release_out", {31'd0, sig_out[0]}, 32'h1);
      chk("release_rise", {28'd0, rise}, 32'h1);
      wait_strobes(2);
      chk("release_level", {28'd0, sig_out}, 32'h5);
      chk_counts("release", 4'b0001, 4'b0000, 1);
      $display("release: out=%b rise_cnt0=%0d any=%0d", sig_out, rise_cnt[0], any_cnt);

      apply_vec(6);

      // Reset mid-count: progress must be discarded, no pulse on exit
      sig_in = 4'b1010;
      wait_strobes(4);
      rst_n = 1'b0;
      cycle();
      cycle();
      chk("midrst_out", {28'd0, sig_out}, 32'hF);
      chk("midrst_pulses", {27'd0, rise, any_change}, 32'h0);
      chk("midrst_fall_lp", {28'd0, fall | long_press}, 32'h0);
      rst_n = 1'b1;
      clear_counts();
      wait_strobes(3);
      chk("midrst_restart", {28'd0, sig_out}, 32'hF);
      chk_counts("midrst_exit", 4'b0000, 4'b0000, 0);
      $display("reset mid-count: out=%b any=%0d", sig_out, any_cnt);

      guard = 0;
      while (sig_out[0] !== 1'b0 && guard < 40) begin
         cycle();
         guard++;
      end
      chk("press_timeout", {31'd0, sig_out[0]}, 32'h0);
      chk("press_out", {28'd0, sig_out}, 32'hA);
      chk_counts("press", 4'b0000, 4'b0101, 1);
      base = strobes;

      // Long press: pulse on 10th strobe after the fall edge
      while (strobes < base + 9) cycle();
      chk("lp_early0", lp_cnt[0], 0);
      chk("lp_early2", lp_cnt[2], 0);
      while (strobes < base + 10) cycle();
      chk("lp_pulse", {28'd0, long_press}, {28'd0, EXP_LP});
      wait_strobes(10);
      chk("lp_once0", lp_cnt[0], {31'd0, EXP_LP[0]});
      chk("lp_once2", lp_cnt[2], {31'd0, EXP_LP[2]});
      chk("lp_total", lp_total, (EXP_LP == 4'b0000) ? 0 : 2);
      $display("long press: lp_cnt0=%0d lp_cnt2=%0d total=%0d", lp_cnt[0], lp_cnt[2], lp_total);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
